alu_op_sched: RTL

// Sequences one arithmetic operation at a time between the hex-command parser and the TX

---
 rtl/alu_op_sched.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_op_sched.sv
// One-at-a-time operation scheduler: ADD/SUB computed locally, MUL dispatched to an
// external multiplier with a stale-done guard window and a bounded wait.
module alu_op_sched #(
    parameter int MUL_GUARD   = 2,
    parameter int MUL_TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        mul_start,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic        mul_done,
    input  logic [31:0] mul_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err
);

    localparam int GW = (MUL_GUARD < 2) ? 1 : $clog2(MUL_GUARD + 1);
    localparam logic [4:0] TMO_LAST = 5'(MUL_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_MUL, OUT} state_t;

    state_t        state_q, state_d;
    logic [15:0]   mul_a_q, mul_a_d;
    logic [15:0]   mul_b_q, mul_b_d;
    logic [31:0]   res_data_q, res_data_d;
    logic          res_err_q, res_err_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [4:0]    tmo_q, tmo_d;

    logic [31:0] a_ext, b_ext;
    logic        guard_over;

    assign a_ext      = {{16{op_a[15]}}, op_a};
    assign b_ext      = {{16{op_b[15]}}, op_b};
    assign guard_over = (guard_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            guard_q    <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            guard_q    <= guard_d;
            tmo_q      <= tmo_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (op_valid) state_d = (op_code == 2'b10) ? LAUNCH : OUT;
            LAUNCH:   state_d = WAIT_MUL;
            WAIT_MUL: if (guard_over && (mul_done || tmo_q == TMO_LAST)) state_d = OUT;
            OUT:      if (res_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        guard_d    = guard_q;
        tmo_d      = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    unique case (op_code)
                        2'b00: begin res_data_d = a_ext + b_ext; res_err_d = 1'b0; end
                        2'b01: begin res_data_d = a_ext - b_ext; res_err_d = 1'b0; end
                        2'b10: begin mul_a_d = op_a; mul_b_d = op_b; end
                        default: begin res_data_d = '0; res_err_d = 1'b1; end
                    endcase
                end
            end
            LAUNCH: begin
                guard_d = GW'(MUL_GUARD);
                tmo_d   = '0;
            end
            WAIT_MUL: begin
                // The multiplier's done level from the previous product may linger just after start.
                if (!guard_over) begin
                    guard_d = guard_q - 1'b1;
                end else if (mul_done) begin
                    res_data_d = mul_result;
                    res_err_d  = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        op_ready  = (state_q == IDLE);
        mul_start = (state_q == LAUNCH);
        res_valid = (state_q == OUT);
    end

    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign res_data = res_data_q;
    assign res_err  = res_err_q;

endmodule
